pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 4: register-address width in bits; must be at least 2.
REQ-002 Parameter LOAD_LAT, default 1: stall cycles per load-use hazard; range 1..7.
REQ-003 Parameter FLUSH_CYC, default 2: cycles for which flush stays asserted after an exception; range 1..7.
REQ-004 Parameter CNT_W, default 16: width of the stall statistics counter.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Ports id_rs1 / id_rs2, input, REG_AW each: source register addresses of the instruction in ID.
REQ-008 Ports id_rs1_used / id_rs2_used, input, 1 each: the corresponding source is actually read.
REQ-009 Ports idex_rd, input, REG_AW; idex_wr, input, 1; idex_mem_rd, input, 1: destination, write-enable and load flag of the instruction in EX.
REQ-010 Ports exmem_rd, input, REG_AW; exmem_wr, input, 1: destination and write-enable of the instruction in MEM.
REQ-011 Port exc_req, input, 1: exception request from the control unit, active-high.
REQ-012 Ports pc_halt / buffer_halt, output, 1 each: hold the PC / hold the IF/ID register.
REQ-013 Port ctrl_bubble, output, 1: zero the control word entering ID/EX.
REQ-014 Ports flush, output, 1: clear IF/ID and ID/EX; exc_ack, output, 1: one-cycle exception acknowledge; exc_busy, output, 1: flush sequence in progress.
REQ-015 Ports fwd_a / fwd_b, output, 2 each: operand forwarding select; 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-016 Port stall_cycles, output, CNT_W: count of cycles in which pc_halt was high.

Function
REQ-017 A hazard match on source N requires all of the following: id_rsN_used=1, id_rsN==idex_rd, idex_wr=1, idex_mem_rd=1 and idex_rd!=0.
REQ-018 load_use is defined as the OR of the hazard matches on rs1 and rs2.
REQ-019 The FSM has states RUN, STALL and FLUSH, held in a registered state vector together with a 3-bit down-counter cnt.
REQ-020 State RUN, when exc_req=0 and load_use=1: pc_halt, buffer_halt and ctrl_bubble are asserted combinationally in the same cycle.
REQ-021 From RUN with a stall: if LOAD_LAT=1, the FSM stays in RUN; otherwise it goes to STALL with cnt=LOAD_LAT-1.
REQ-022 State STALL: pc_halt, buffer_halt and ctrl_bubble are all 1; cnt decrements each cycle, and when cnt==1 the next state is RUN.
REQ-023 A load-use stall therefore holds the halts for exactly LOAD_LAT consecutive cycles, and load_use is not re-evaluated while in STALL.
REQ-024 exc_req=1 in RUN or STALL has priority over load_use: next state FLUSH with cnt=FLUSH_CYC, and exc_ack=1 in that same cycle (Mealy).
REQ-025 When exc_req=1, halts are suppressed in that cycle (pc_halt=buffer_halt=ctrl_bubble=0) so the PC can be redirected.
REQ-026 State FLUSH: flush=1, exc_busy=1 and all halts 0; cnt decrements each cycle, and when cnt==1 the next state is RUN.
REQ-027 exc_req is ignored while in FLUSH: exc_ack stays 0 and cnt is not reloaded.
REQ-028 fwd_a is 10 when id_rs1_used, idex_wr, !idex_mem_rd, idex_rd==id_rs1 and idex_rd!=0 all hold.
REQ-029 Otherwise fwd_a is 01 when id_rs1_used, exmem_wr, exmem_rd==id_rs1 and exmem_rd!=0 all hold; otherwise fwd_a is 00.
REQ-030 fwd_b is derived identically from id_rs2; EX/MEM takes priority over MEM/WB.
REQ-031 fwd_a and fwd_b are combinational and are independent of the FSM state.
REQ-032 stall_cycles increments on each clock edge at which pc_halt=1 and saturates at all-ones without wrapping.
REQ-033 Register 0 never causes a hazard or a forward.

Reset
REQ-034 While rst=1 (asynchronous): state=RUN, cnt=0 and stall_cycles=0.
REQ-035 While rst=1, the combinational outputs evaluate with state=RUN.
REQ-036 A reset asserted during STALL or FLUSH aborts the sequence immediately, and no stall or flush cycle resumes after release.

Verification
REQ-037 LOAD_LAT=1: idex_rd=3, idex_wr=1, idex_mem_rd=1, id_rs2=3, id_rs2_used=1 -> halts high for exactly 1 cycle and stall_cycles=1.
REQ-038 LOAD_LAT=3, same stimulus -> halts high for 3 consecutive cycles, state returns to RUN and stall_cycles=3.
REQ-039 exc_req=1 during the 2nd STALL cycle with FLUSH_CYC=2 -> exc_ack pulses 1 cycle, halts drop in that cycle, and flush=1 for the next 2 cycles.
REQ-040 Both forwarding sources match id_rs1=5 (idex_rd=exmem_rd=5, idex_wr=exmem_wr=1, idex_mem_rd=0) -> fwd_a=10; same stimulus with all addresses 0 -> fwd_a=00.
REQ-041 rst pulsed during FLUSH -> flush=0 and exc_busy=0 immediately, with no flush after release.
REQ-042 CNT_W=4 with more than 15 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, exception flush sequencing,
// operand forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_wr,
    input  logic              idex_mem_rd,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_wr,
    input  logic              exc_req,
    output logic              pc_halt,
    output logic              buffer_halt,
    output logic              ctrl_bubble,
    output logic              flush,
    output logic              exc_ack,
    output logic              exc_busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT      state;
    logic [2:0] cnt;
    logic       hazardRs1;
    logic       hazardRs2;
    logic       loadUse;
    logic       haltReq;

    // A load in EX whose destination is read in ID cannot be forwarded in time.
    always_comb begin
        hazardRs1 = id_rs1_used && idex_wr && idex_mem_rd
                    && (id_rs1 == idex_rd) && (idex_rd != '0);
        hazardRs2 = id_rs2_used && idex_wr && idex_mem_rd
                    && (id_rs2 == idex_rd) && (idex_rd != '0);
        loadUse   = hazardRs1 || hazardRs2;
    end

    // Exceptions win over stalls and drop the halts so the PC can be redirected.
    always_comb begin
        haltReq  = 1'b0;
        exc_ack  = 1'b0;
        flush    = 1'b0;
        exc_busy = 1'b0;
        case (state)
            RUN: begin
                if (exc_req)      exc_ack = 1'b1;
                else if (loadUse) haltReq = 1'b1;
            end
            STALL: begin
                if (exc_req) exc_ack = 1'b1;
                else         haltReq = 1'b1;
            end
            FLUSH: begin
                flush    = 1'b1;
                exc_busy = 1'b1;
            end
            default: begin
                haltReq = 1'b0;
            end
        endcase
        pc_halt     = haltReq;
        buffer_halt = haltReq;
        ctrl_bubble = haltReq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (exc_req) begin
                        state <= FLUSH;
                        cnt   <= 3'(FLUSH_CYC);
                    end else if (loadUse && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        cnt   <= 3'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (exc_req) begin
                        state <= FLUSH;
                        cnt   <= 3'(FLUSH_CYC);
                    end else if (cnt == 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    if (cnt == 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // EX/MEM result is younger than MEM/WB, so it takes priority.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (id_rs1_used && idex_wr && !idex_mem_rd && (idex_rd == id_rs1) && (idex_rd != '0))
            fwd_a = 2'b10;
        else if (id_rs1_used && exmem_wr && (exmem_rd == id_rs1) && (exmem_rd != '0))
            fwd_a = 2'b01;
        if (id_rs2_used && idex_wr && !idex_mem_rd && (idex_rd == id_rs2) && (idex_rd != '0))
            fwd_b = 2'b10;
        else if (id_rs2_used && exmem_wr && (exmem_rd == id_rs2) && (exmem_rd != '0))
            fwd_b = 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_halt && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=1 and one with
// LOAD_LAT=3 / CNT_W=4 share the same stimulus so both latencies are checked together.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] idRs1, idRs2, idexRd, exmemRd;
    logic       idRs1Used, idRs2Used, idexWr, idexMemRd, exmemWr, excReq;

    logic        pcHaltA, bufferHaltA, ctrlBubbleA, flushA, excAckA, excBusyA;
    logic [1:0]  fwdAA, fwdBA;
    logic [15:0] stallCyclesA;
    logic        pcHaltB, bufferHaltB, ctrlBubbleB, flushB, excAckB, excBusyB;
    logic [1:0]  fwdAB, fwdBB;
    logic [3:0]  stallCyclesB;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(1), .FLUSH_CYC(3), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
        .idex_rd(idexRd), .idex_wr(idexWr), .idex_mem_rd(idexMemRd),
        .exmem_rd(exmemRd), .exmem_wr(exmemWr), .exc_req(excReq),
        .pc_halt(pcHaltA), .buffer_halt(bufferHaltA), .ctrl_bubble(ctrlBubbleA),
        .flush(flushA), .exc_ack(excAckA), .exc_busy(excBusyA),
        .fwd_a(fwdAA), .fwd_b(fwdBA), .stall_cycles(stallCyclesA)
    );

    pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
        .idex_rd(idexRd), .idex_wr(idexWr), .idex_mem_rd(idexMemRd),
        .exmem_rd(exmemRd), .exmem_wr(exmemWr), .exc_req(excReq),
        .pc_halt(pcHaltB), .buffer_halt(bufferHaltB), .ctrl_bubble(ctrlBubbleB),
        .flush(flushB), .exc_ack(excAckB), .exc_busy(excBusyB),
        .fwd_a(fwdAB), .fwd_b(fwdBB), .stall_cycles(stallCyclesB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; checks run 1ns later, well clear of posedge.
    task automatic applyStimulus(input logic [3:0] rs1, input logic rs1Used,
                                 input logic [3:0] rs2, input logic rs2Used,
                                 input logic [3:0] exRd, input logic exWr, input logic exLoad,
                                 input logic [3:0] memRd, input logic memWr, input logic exc);
        @(negedge clk);
        idRs1 = rs1; idRs1Used = rs1Used; idRs2 = rs2; idRs2Used = rs2Used;
        idexRd = exRd; idexWr = exWr; idexMemRd = exLoad;
        exmemRd = memRd; exmemWr = memWr; excReq = exc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pcHaltA, flushA, excBusyA, excAckA, stallCyclesA} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_A: got %h expected 00000", {pcHaltA, flushA, excBusyA, excAckA, stallCyclesA});
        end
        checks++;
        if ({pcHaltB, flushB, excBusyB, excAckB, stallCyclesB} !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_B: got %h expected 00", {pcHaltB, flushB, excBusyB, excAckB, stallCyclesB});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        applyStimulus(0, 0, 3, 1, 3, 1, 1, 0, 0, 0);
        checks++;
        if ({pcHaltA, bufferHaltA, ctrlBubbleA, pcHaltB, bufferHaltB, ctrlBubbleB} !== 6'b111111) begin
            errors++;
            $display("[TB] FAIL loaduse_first: got %b expected 111111",
                     {pcHaltA, bufferHaltA, ctrlBubbleA, pcHaltB, bufferHaltB, ctrlBubbleB});
        end
        checks++;
        if (fwdBA !== 2'b00) begin
            errors++;
            $display("[TB] FAIL loaduse_nofwd: got %b expected 00", fwdBA);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pcHaltA, pcHaltB, stallCyclesA} !== {2'b01, 16'd1}) begin
            errors++;
            $display("[TB] FAIL loaduse_cyc2: got %b/%b cnt %0d expected 0/1 cnt 1", pcHaltA, pcHaltB, stallCyclesA);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pcHaltB, bufferHaltB, ctrlBubbleB} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL loaduse_cyc3: got %b expected 111", {pcHaltB, bufferHaltB, ctrlBubbleB});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pcHaltB, stallCyclesB, stallCyclesA} !== {1'b0, 4'd3, 16'd1}) begin
            errors++;
            $display("[TB] FAIL loaduse_end: got halt %b B %0d A %0d expected 0 3 1", pcHaltB, stallCyclesB, stallCyclesA);
        end
    endtask

    task automatic test_exception();
        applyStimulus(0, 0, 3, 1, 3, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pcHaltB !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exc_pre_stall: got %b expected 1", pcHaltB);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({excAckB, pcHaltB, bufferHaltB, ctrlBubbleB, flushB} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL exc_ack_B: got %b expected 10000", {excAckB, pcHaltB, bufferHaltB, ctrlBubbleB, flushB});
        end
        checks++;
        if ({excAckA, pcHaltA, flushA} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL exc_ack_A: got %b expected 100", {excAckA, pcHaltA, flushA});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({flushB, excBusyB, excAckB, pcHaltB, flushA, excBusyA} !== 6'b110011) begin
            errors++;
            $display("[TB] FAIL flush_cyc1: got %b expected 110011", {flushB, excBusyB, excAckB, pcHaltB, flushA, excBusyA});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({flushB, excBusyB, excAckB, flushA, excAckA} !== 5'b11010) begin
            errors++;
            $display("[TB] FAIL flush_cyc2_excignored: got %b expected 11010", {flushB, excBusyB, excAckB, flushA, excAckA});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({flushB, excBusyB, flushA} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL flush_cyc3: got %b expected 001", {flushB, excBusyB, flushA});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({flushA, excBusyA, stallCyclesA, stallCyclesB} !== {2'b00, 16'd2, 4'd5}) begin
            errors++;
            $display("[TB] FAIL flush_end: got flushA %b A %0d B %0d expected 0 2 5", flushA, stallCyclesA, stallCyclesB);
        end
    endtask

    task automatic test_forwarding();
        applyStimulus(5, 1, 0, 0, 5, 1, 0, 5, 1, 0);
        checks++;
        if ({fwdAA, fwdAB, pcHaltA, pcHaltB} !== 6'b101000) begin
            errors++;
            $display("[TB] FAIL fwd_both_match: got %b expected 101000", {fwdAA, fwdAB, pcHaltA, pcHaltB});
        end
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        checks++;
        if ({fwdAA, fwdAB} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL fwd_reg0: got %b expected 0000", {fwdAA, fwdAB});
        end
        applyStimulus(5, 1, 0, 0, 6, 1, 0, 5, 1, 0);
        checks++;
        if (fwdAA !== 2'b01) begin
            errors++;
            $display("[TB] FAIL fwd_memwb_a: got %b expected 01", fwdAA);
        end
        applyStimulus(5, 0, 0, 0, 5, 1, 0, 5, 1, 0);
        checks++;
        if (fwdAA !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fwd_unused_a: got %b expected 00", fwdAA);
        end
        applyStimulus(0, 0, 7, 1, 7, 0, 0, 7, 1, 0);
        checks++;
        if ({fwdAA, fwdBA, fwdBB} !== 6'b000101) begin
            errors++;
            $display("[TB] FAIL fwd_memwb_b: got %b expected 000101", {fwdAA, fwdBA, fwdBB});
        end
        applyStimulus(0, 0, 7, 1, 7, 1, 0, 9, 1, 0);
        checks++;
        if (fwdBA !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fwd_exmem_b: got %b expected 10", fwdBA);
        end
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if ({pcHaltA, pcHaltB, fwdAA} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reg0_no_hazard: got %b expected 0000", {pcHaltA, pcHaltB, fwdAA});
        end
        applyStimulus(9, 1, 9, 1, 9, 1, 0, 9, 1, 0);
        checks++;
        if ({fwdAA, fwdBA, fwdAB, fwdBB} !== 8'b10101010) begin
            errors++;
            $display("[TB] FAIL fwd_dual: got %b expected 10101010", {fwdAA, fwdBA, fwdAB, fwdBB});
        end
    endtask

    task automatic test_reset_abort();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({flushA, flushB} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL abort_pre_flush: got %b expected 11", {flushA, flushB});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({flushA, excBusyA, flushB, excBusyB} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_flush_async: got %b expected 0000", {flushA, excBusyA, flushB, excBusyB});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({flushA, flushB, stallCyclesA, stallCyclesB} !== 22'h0) begin
                errors++;
                $display("[TB] FAIL abort_after_release%0d: got %h expected 0", i, {flushA, flushB, stallCyclesA, stallCyclesB});
            end
        end
        applyStimulus(0, 0, 3, 1, 3, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pcHaltB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_stall_async: got %b expected 0", pcHaltB);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pcHaltB, stallCyclesB} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL abort_stall_release: got %b expected 00000", {pcHaltB, stallCyclesB});
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 0, 3, 1, 3, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stallCyclesB !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturate_B: got %0d expected 15", stallCyclesB);
        end
        checks++;
        if (stallCyclesA !== 16'd20) begin
            errors++;
            $display("[TB] FAIL count_A: got %0d expected 20", stallCyclesA);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_exception();
        test_forwarding();
        test_reset_abort();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
